// File: rtl/hs_frame_sequencer.sv
// Raster sequencer for the Horn-Schunck optical-flow datapath: input/centre counters and output sync.
// Optional frame counter output enabled by defining HS_SEQ_FRAME_CNT_EN.
module hs_frame_sequencer #(
    parameter int unsigned IMAGE_WIDTH  = 584,
    parameter int unsigned IMAGE_HEIGHT = 388,
    parameter int unsigned PIPE_LATENCY = 8,
    parameter int unsigned CNT_W        = 10
) (
    input  logic             clk,
    input  logic             reset,
`ifdef HS_SEQ_FRAME_CNT_EN
    output logic [15:0]      io_frame_count,
`endif
    input  logic             io_frame_sync_in,
    output logic             io_in_valid,
    output logic [CNT_W-1:0] io_in_col,
    output logic [CNT_W-1:0] io_in_row,
    output logic             io_lb_wr_en,
    output logic             io_ctr_valid,
    output logic [CNT_W-1:0] io_ctr_col,
    output logic [CNT_W-1:0] io_ctr_row,
    output logic             io_ctr_border,
    output logic             io_frame_sync_out,
    output logic             io_busy,
    output logic             io_frame_err
);

    localparam int unsigned      LEAD_W    = $clog2(IMAGE_WIDTH + 2);
    localparam logic [CNT_W-1:0] COL_LAST  = CNT_W'(IMAGE_WIDTH - 1);
    localparam logic [CNT_W-1:0] ROW_LAST  = CNT_W'(IMAGE_HEIGHT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [LEAD_W-1:0] LEAD_END = LEAD_W'(IMAGE_WIDTH + 1);
    localparam logic [LEAD_W-1:0] LEAD_ONE = LEAD_W'(1);

    typedef enum logic [1:0] {StIdle, StLead, StRun, StTail} state_e;

    state_e                  r_state, w_state_d;
    logic                    r_in_active;
    logic [CNT_W-1:0]        r_in_col, r_in_row;
    logic                    r_lead_active;
    logic [LEAD_W-1:0]       r_lead_cnt;
    logic                    r_cc_active;
    logic [CNT_W-1:0]        r_cc_col, r_cc_row;
    logic                    r_ctr_valid, r_ctr_border;
    logic [CNT_W-1:0]        r_ctr_col, r_ctr_row;
    logic [PIPE_LATENCY-1:0] r_pipe_sync, r_pipe_vld, w_pipe_sync_d, w_pipe_vld_d;

    logic             w_sync, w_err, w_in_valid, w_in_last, w_lead_done;
    logic             w_c_start, w_c_valid, w_c_last, w_c_border, w_tap, w_ctr_last_q;
    logic [CNT_W-1:0] w_in_col, w_in_row, w_c_col, w_c_row;

    assign w_sync      = io_frame_sync_in;
    assign w_err       = w_sync & r_in_active;
    assign w_in_valid  = w_sync | r_in_active;
    assign w_in_col    = w_sync ? '0 : r_in_col;
    assign w_in_row    = w_sync ? '0 : r_in_row;
    assign w_in_last   = w_in_valid && (w_in_col == COL_LAST) && (w_in_row == ROW_LAST);
    assign w_lead_done = r_lead_active && (r_lead_cnt == LEAD_END);

    // An error sync kills whatever centre is running, including one starting this cycle.
    assign w_c_start  = w_lead_done & ~w_err;
    assign w_c_valid  = w_c_start | (r_cc_active & ~w_err);
    assign w_c_col    = (w_c_start || !w_c_valid) ? '0 : r_cc_col;
    assign w_c_row    = (w_c_start || !w_c_valid) ? '0 : r_cc_row;
    assign w_c_last   = w_c_valid && (w_c_col == COL_LAST) && (w_c_row == ROW_LAST);
    assign w_c_border = w_c_valid && ((w_c_col == '0) || (w_c_col == COL_LAST) ||
                                      (w_c_row == '0) || (w_c_row == ROW_LAST));

    assign w_tap        = r_ctr_valid && (r_ctr_col == '0) && (r_ctr_row == '0);
    assign w_ctr_last_q = r_ctr_valid && (r_ctr_col == COL_LAST) && (r_ctr_row == ROW_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_in_active <= 1'b0;
            r_in_col    <= '0;
            r_in_row    <= '0;
        end else if (w_in_valid) begin
            r_in_active <= ~w_in_last;
            r_in_col    <= (w_in_last || w_in_col == COL_LAST) ? '0 : w_in_col + CNT_ONE;
            if (w_in_last)                r_in_row <= '0;
            else if (w_in_col == COL_LAST) r_in_row <= w_in_row + CNT_ONE;
            else                           r_in_row <= w_in_row;
        end
    end

    // Every sync, legal or not, (re)arms the lead that delays the centre by one row plus one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lead_active <= 1'b0;
            r_lead_cnt    <= '0;
        end else if (w_sync) begin
            r_lead_active <= 1'b1;
            r_lead_cnt    <= LEAD_ONE;
        end else if (w_lead_done) begin
            r_lead_active <= 1'b0;
            r_lead_cnt    <= '0;
        end else if (r_lead_active) begin
            r_lead_cnt    <= r_lead_cnt + LEAD_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cc_active <= 1'b0;
            r_cc_col    <= '0;
            r_cc_row    <= '0;
        end else if (w_err) begin
            r_cc_active <= 1'b0;
            r_cc_col    <= '0;
            r_cc_row    <= '0;
        end else if (w_c_valid) begin
            r_cc_active <= ~w_c_last;
            r_cc_col    <= (w_c_last || w_c_col == COL_LAST) ? '0 : w_c_col + CNT_ONE;
            if (w_c_last)                 r_cc_row <= '0;
            else if (w_c_col == COL_LAST) r_cc_row <= w_c_row + CNT_ONE;
            else                          r_cc_row <= w_c_row;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ctr_valid  <= 1'b0;
            r_ctr_col    <= '0;
            r_ctr_row    <= '0;
            r_ctr_border <= 1'b0;
            r_pipe_sync  <= '0;
            r_pipe_vld   <= '0;
        end else begin
            r_ctr_valid  <= w_c_valid;
            r_ctr_col    <= w_c_col;
            r_ctr_row    <= w_c_row;
            r_ctr_border <= w_c_border;
            r_pipe_sync  <= w_pipe_sync_d;
            r_pipe_vld   <= w_pipe_vld_d;
        end
    end

    // Parallel valid shift keeps busy asserted until the last u/v pixel leaves the datapath.
    always_comb begin
        w_pipe_sync_d = '0;
        w_pipe_vld_d  = '0;
        if (!w_err) begin
            w_pipe_sync_d[0] = w_tap;
            w_pipe_vld_d[0]  = r_ctr_valid;
            for (int i = 1; i < int'(PIPE_LATENCY); i++) begin
                w_pipe_sync_d[i] = r_pipe_sync[i-1];
                w_pipe_vld_d[i]  = r_pipe_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= StIdle;
        else        r_state <= w_state_d;
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle: if (w_sync) w_state_d = StLead;
            StLead: if (!w_err && w_lead_done) w_state_d = StRun;
            StRun: begin
                if (w_err)            w_state_d = StLead;
                else if (!w_in_valid) w_state_d = StTail;
            end
            StTail: begin
                if (w_sync)            w_state_d = StLead;
                else if (w_ctr_last_q) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

`ifdef HS_SEQ_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                          r_frame_cnt <= '0;
        else if (r_pipe_sync[PIPE_LATENCY-1]) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
    assign io_frame_count = r_frame_cnt;
`endif

    assign io_in_valid       = w_in_valid;
    assign io_in_col         = w_in_col;
    assign io_in_row         = w_in_row;
    assign io_lb_wr_en       = w_in_valid;
    assign io_ctr_valid      = r_ctr_valid;
    assign io_ctr_col        = r_ctr_col;
    assign io_ctr_row        = r_ctr_row;
    assign io_ctr_border     = r_ctr_border;
    assign io_frame_sync_out = r_pipe_sync[PIPE_LATENCY-1];
    assign io_busy           = (r_state != StIdle) || (|r_pipe_vld) || (|r_pipe_sync);
    assign io_frame_err      = w_err;

endmodule
